distortion_multimode: RTL

//  Multi-mode, multi-channel audio distortion stage: gain, then bypass/hard-clip/soft-clip/asymmetric-fuzz shaping.

---
 rtl/distortion_pkg.sv | 15 +
 rtl/distortion_shaper.sv | 64 ++++++
 rtl/distortion_multimode.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/distortion_pkg.sv
// Shared definitions for the multi-mode distortion stage: mode encodings and
// fixed-point constants used by the gain and shaping stages.
package distortion_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'b00,
      MODE_HARD   = 2'b01,
      MODE_SOFT   = 2'b10,
      MODE_FUZZ   = 2'b11
   } mode_e;

   localparam int GAIN_FRAC        = 4;
   localparam int SOFT_SLOPE_SHIFT = 2;

endpackage

// File: rtl/distortion_shaper.sv
// Combinational waveshaper: applies the selected transfer curve to a gained
// sample against threshold T and reports whether the value was altered.
module distortion_shaper
   import distortion_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic signed [WIDTH-1:0] i_g,
   input  mode_e                   i_mode,
   input  logic        [WIDTH-2:0] i_thresh,
   output logic signed [WIDTH-1:0] o_y,
   output logic                    o_clipped
);

   // One extra bit so that |-2^(WIDTH-1)| and -T are representable.
   localparam int XW = WIDTH + 1;
   localparam logic signed [XW-1:0] X_MAX = XW'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [XW-1:0] X_MIN = ~X_MAX;

   logic signed [XW-1:0] w_gx;
   logic signed [XW-1:0] w_t;
   logic signed [XW-1:0] w_thalf;
   logic signed [XW-1:0] w_abs;
   logic signed [XW-1:0] w_knee;
   logic signed [XW-1:0] w_yx;
   logic                 w_neg;

   assign w_gx    = XW'(i_g);
   assign w_t     = $signed({2'b00, i_thresh});
   assign w_thalf = $signed({3'b000, i_thresh[WIDTH-2:1]});
   assign w_neg   = w_gx[XW-1];
   assign w_abs   = w_neg ? -w_gx : w_gx;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_yx   = w_gx;
      w_knee = w_t + ((w_abs - w_t) >>> SOFT_SLOPE_SHIFT);
      case (i_mode)
         MODE_HARD: begin
            if (w_gx > w_t)       w_yx = w_t;
            else if (w_gx < -w_t) w_yx = -w_t;
         end
         MODE_SOFT: begin
            if (w_abs > w_t) w_yx = w_neg ? -w_knee : w_knee;
         end
         MODE_FUZZ: begin
            if (!w_neg) begin
               if (w_gx > w_t) w_yx = w_t;
            end else if (w_gx < -w_thalf) begin
               w_yx = -w_thalf;
            end
         end
         default: w_yx = w_gx;
      endcase
   end

   always_comb begin
      o_y = w_yx[WIDTH-1:0];
      if (w_yx > X_MAX)      o_y = X_MAX[WIDTH-1:0];
      else if (w_yx < X_MIN) o_y = X_MIN[WIDTH-1:0];
      o_clipped = (o_y != i_g);
   end

endmodule

// File: rtl/distortion_multimode.sv
// Three-stage valid/ready distortion pipeline: S0 captures sample and config,
// S1 applies saturating gain, S2 holds the shaped output; sticky clip flags per channel.
module distortion_multimode
   import distortion_pkg::*;
#(
   parameter  int WIDTH    = 16,
   parameter  int GAIN_W   = 8,
   parameter  int CHANNELS = 2,
   localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_data,
   input  logic        [CW-1:0]    in_chan,
   input  logic        [1:0]       cfg_mode,
   input  logic        [GAIN_W-1:0] cfg_gain,
   input  logic        [WIDTH-2:0] cfg_thresh,
   input  logic                    clip_clr,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_data,
   output logic        [CW-1:0]    out_chan,
   output logic        [CHANNELS-1:0] clip_flag
);

   localparam int PW = WIDTH + GAIN_W + 1;
   localparam logic signed [PW-1:0] P_MAX = PW'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [PW-1:0] P_MIN = ~P_MAX;

   logic                    r_s0_valid, r_s1_valid, r_s2_valid;
   logic signed [WIDTH-1:0] r_s0_data,  r_s1_g,     r_s2_data;
   logic        [CW-1:0]    r_s0_chan,  r_s1_chan,  r_s2_chan;
   mode_e                   r_s0_mode,  r_s1_mode;
   logic        [WIDTH-2:0] r_s0_thresh, r_s1_thresh;
   logic        [GAIN_W-1:0] r_s0_gain;
   logic                    r_s1_sat,   r_s2_hit;
   logic        [CHANNELS-1:0] r_clip_flag;

   logic                    w_s0_load, w_s1_load, w_s2_load;
   logic signed [PW-1:0]    w_prod, w_gshift;
   logic signed [WIDTH-1:0] w_g, w_y;
   logic                    w_sat, w_clipped;
   logic        [CHANNELS-1:0] w_flag_set;

   // Each stage loads when empty or when its content moves on this cycle.
   assign w_s2_load = !r_s2_valid || out_ready;
   assign w_s1_load = !r_s1_valid || w_s2_load;
   assign w_s0_load = !r_s0_valid || w_s1_load;
   assign in_ready  = w_s0_load;

   assign w_prod   = PW'(r_s0_data) * PW'($signed({1'b0, r_s0_gain}));
   assign w_gshift = w_prod >>> GAIN_FRAC;

   always_comb begin
      w_g   = r_s0_data;
      w_sat = 1'b0;
      if (r_s0_mode != MODE_BYPASS) begin
         if (w_gshift > P_MAX) begin
            w_g   = P_MAX[WIDTH-1:0];
            w_sat = 1'b1;
         end else if (w_gshift < P_MIN) begin
            w_g   = P_MIN[WIDTH-1:0];
            w_sat = 1'b1;
         end else begin
            w_g   = w_gshift[WIDTH-1:0];
         end
      end
   end

   distortion_shaper #(.WIDTH(WIDTH)) u_shaper (
      .i_g       (r_s1_g),
      .i_mode    (r_s1_mode),
      .i_thresh  (r_s1_thresh),
      .o_y       (w_y),
      .o_clipped (w_clipped)
   );

   always_comb begin
      w_flag_set = '0;
      if (r_s2_valid && out_ready && r_s2_hit && (int'(r_s2_chan) < CHANNELS))
         w_flag_set[r_s2_chan] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s0_valid  <= 1'b0;
         r_s0_data   <= '0;
         r_s0_chan   <= '0;
         r_s0_mode   <= MODE_BYPASS;
         r_s0_gain   <= '0;
         r_s0_thresh <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_g      <= '0;
         r_s1_chan   <= '0;
         r_s1_mode   <= MODE_BYPASS;
         r_s1_thresh <= '0;
         r_s1_sat    <= 1'b0;
         r_s2_valid  <= 1'b0;
         r_s2_data   <= '0;
         r_s2_chan   <= '0;
         r_s2_hit    <= 1'b0;
         r_clip_flag <= '0;
      end else begin
         if (w_s0_load) begin
            r_s0_valid <= in_valid;
            if (in_valid) begin
               r_s0_data   <= in_data;
               r_s0_chan   <= in_chan;
               r_s0_mode   <= mode_e'(cfg_mode);
               r_s0_gain   <= cfg_gain;
               r_s0_thresh <= cfg_thresh;
            end
         end
         if (w_s1_load) begin
            r_s1_valid <= r_s0_valid;
            if (r_s0_valid) begin
               r_s1_g      <= w_g;
               r_s1_sat    <= w_sat;
               r_s1_chan   <= r_s0_chan;
               r_s1_mode   <= r_s0_mode;
               r_s1_thresh <= r_s0_thresh;
            end
         end
         if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_data <= w_y;
               r_s2_chan <= r_s1_chan;
               r_s2_hit  <= r_s1_sat | w_clipped;
            end
         end
         // A set on the same cycle as a clear wins for that channel.
         r_clip_flag <= (clip_clr ? '0 : r_clip_flag) | w_flag_set;
      end
   end

   assign out_valid = r_s2_valid;
   assign out_data  = r_s2_data;
   assign out_chan  = r_s2_chan;
   assign clip_flag = r_clip_flag;

endmodule
